// File: rtl/otp_keystream_gen.sv
// One-time pad source: a seeded 32-bit Galois LFSR is stepped MSG_SIZE times per request,
// and the assembled pad is presented once on a valid/ready handshake, then cleared.
module otp_keystream_gen #(
  parameter int          MSG_SIZE = 8,
  parameter logic [31:0] TAPS     = 32'hB4BCD35C,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_load,
  input  logic [31:0]         seed,
  output logic                seed_err,
  input  logic                req,
  output logic                busy,
  output logic                otp_valid,
  input  logic                otp_ready,
  output logic [MSG_SIZE-1:0] otp,
  output logic [CNT_W-1:0]    pad_count
);

  localparam int BCW = $clog2(MSG_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [31:0]         lfsr_r, lfsr_s;
  logic                seeded_r, seeded_s;
  logic [MSG_SIZE-1:0] pad_r, pad_s;
  logic [BCW-1:0]      bitcnt_r, bitcnt_s;
  logic [MSG_SIZE-1:0] otp_r, otp_s;
  logic                otp_valid_r, otp_valid_s;
  logic                busy_r, busy_s;
  logic                seed_err_r, seed_err_s;
  logic [CNT_W-1:0]    pad_count_r, pad_count_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0000_0000);
  endfunction

  // Next-state and datapath: the LFSR only advances in FILL; otp is loaded one cycle after entering PRESENT.
  always_comb begin
    state_s     = state_r;
    lfsr_s      = lfsr_r;
    seeded_s    = seeded_r;
    pad_s       = pad_r;
    bitcnt_s    = bitcnt_r;
    otp_s       = otp_r;
    otp_valid_s = otp_valid_r;
    seed_err_s  = 1'b0;
    pad_count_s = pad_count_r;
    case (state_r)
      IDLE: begin
        if (seed_load) begin
          if (seed != 32'h0000_0000) begin
            lfsr_s   = seed;
            seeded_s = 1'b1;
          end else begin
            seed_err_s = 1'b1;
          end
        end else if (req && seeded_r) begin
          state_s  = FILL;
          pad_s    = '0;
          bitcnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        seed_err_s = seed_load;
        lfsr_s     = lfsr_step(lfsr_r);
        pad_s      = {pad_r[MSG_SIZE-2:0], lfsr_r[0]};
        bitcnt_s   = bitcnt_r + BCW'(1);
        if (bitcnt_r == BCW'(MSG_SIZE - 1)) begin
          state_s = PRESENT;
        end else begin
          state_s = FILL;
        end
      end
      PRESENT: begin
        seed_err_s = seed_load;
        if (!otp_valid_r) begin
          otp_valid_s = 1'b1;
          otp_s       = pad_r;
        end else if (otp_ready) begin
          // Consumed pad is wiped so the same key can never be presented twice.
          otp_valid_s = 1'b0;
          otp_s       = '0;
          pad_s       = '0;
          state_s     = IDLE;
          if (pad_count_r != {CNT_W{1'b1}}) begin
            pad_count_s = pad_count_r + CNT_W'(1);
          end else begin
            pad_count_s = pad_count_r;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      default: begin
        state_s     = IDLE;
        otp_valid_s = 1'b0;
        otp_s       = '0;
        pad_s       = '0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset discards any partial or unconsumed pad and the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lfsr_r      <= 32'h0000_0000;
      seeded_r    <= 1'b0;
      pad_r       <= '0;
      bitcnt_r    <= '0;
      otp_r       <= '0;
      otp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      seed_err_r  <= 1'b0;
      pad_count_r <= '0;
    end else begin
      state_r     <= state_s;
      lfsr_r      <= lfsr_s;
      seeded_r    <= seeded_s;
      pad_r       <= pad_s;
      bitcnt_r    <= bitcnt_s;
      otp_r       <= otp_s;
      otp_valid_r <= otp_valid_s;
      busy_r      <= busy_s;
      seed_err_r  <= seed_err_s;
      pad_count_r <= pad_count_s;
    end
  end

  assign seed_err  = seed_err_r;
  assign busy      = busy_r;
  assign otp_valid = otp_valid_r;
  assign otp       = otp_r;
  assign pad_count = pad_count_r;

endmodule

// File: tb/tb_otp_keystream_gen.sv
// Bench for otp_keystream_gen: table of IDLE control vectors, scoreboarded pads against an
// LFSR reference model, plus hold, saturation (CNT_W=2 twin) and mid-FILL reset sequences.
module tb_otp_keystream_gen;

  localparam int          MSG  = 8;
  localparam logic [31:0] TAPS = 32'hB4BCD35C;

  logic        clk = 1'b0;
  logic        rst_n, seed_load, req, otp_ready;
  logic [31:0] seed;
  logic        seed_err, busy, otp_valid;
  logic [MSG-1:0] otp;
  logic [15:0] pad_count;
  logic        seed_err2, busy2, otp_valid2;
  logic [MSG-1:0] otp2;
  logic [1:0]  pad_count2;

  otp_keystream_gen #(.MSG_SIZE(MSG), .TAPS(TAPS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .seed_err(seed_err),
    .req(req), .busy(busy), .otp_valid(otp_valid), .otp_ready(otp_ready), .otp(otp),
    .pad_count(pad_count));

  otp_keystream_gen #(.MSG_SIZE(MSG), .TAPS(TAPS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .seed_err(seed_err2),
    .req(req), .busy(busy2), .otp_valid(otp_valid2), .otp_ready(otp_ready), .otp(otp2),
    .pad_count(pad_count2));

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [31:0] sd;
    logic        rq;
    logic        rdy;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  int vec_cnt = 0;
  int miss_cnt = 0;
  logic [31:0]    m_lfsr;
  bit             m_seeded;
  int             m_consumed;
  logic [MSG-1:0] sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_gen(output logic [MSG-1:0] p);
    logic b;
    p = '0;
    for (int i = 0; i < MSG; i++) begin
      b      = m_lfsr[0];
      p      = {p[MSG-2:0], b};
      m_lfsr = (m_lfsr >> 1) ^ (b ? TAPS : 32'h0);
    end
  endtask

  task automatic start_pad(input bit expect_ok);
    logic [MSG-1:0] p;
    int k;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("busy_after_req", {63'd0, busy}, {63'd0, expect_ok});
    if (expect_ok) begin
      model_gen(p);
      sbq.push_back(p);
      k = 1;
      while (!otp_valid && k < 200) begin
        tick();
        k++;
      end
      check("latency", 64'(k), 64'(MSG + 2));
      check("valid_sat", {63'd0, otp_valid2}, 64'd1);
    end else begin
      repeat (MSG + 3) tick();
      check("ignored_valid", {63'd0, otp_valid}, 64'd0);
      check("ignored_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic consume();
    logic [MSG-1:0] p;
    int sat;
    if (sbq.size() == 0) begin
      miss_cnt++;
      $display("FAIL scoreboard: pad present but no expectation queued");
      p = 'x;
    end else begin
      p = sbq.pop_front();
    end
    check("pad", {56'd0, otp}, {56'd0, p});
    check("pad_sat", {56'd0, otp2}, {56'd0, p});
    otp_ready = 1'b1;
    tick();
    otp_ready = 1'b0;
    m_consumed++;
    sat = (m_consumed > 3) ? 3 : m_consumed;
    check("otp_cleared", {56'd0, otp}, 64'd0);
    check("valid_cleared", {63'd0, otp_valid}, 64'd0);
    check("busy_cleared", {63'd0, busy}, 64'd0);
    check("pad_count", {48'd0, pad_count}, 64'(m_consumed));
    check("pad_count_sat", {62'd0, pad_count2}, 64'(sat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   errs;
    tbl[0] = '{load: 1'b1, sd: 32'h0, rq: 1'b0, rdy: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[1] = '{load: 1'b0, sd: 32'h0, rq: 1'b1, rdy: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};
    tbl[2] = '{load: 1'b0, sd: 32'h0, rq: 1'b0, rdy: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
    tbl[3] = '{load: 1'b1, sd: 32'h1, rq: 1'b0, rdy: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};
    tbl[4] = '{load: 1'b1, sd: 32'h0, rq: 1'b1, rdy: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[5] = '{load: 1'b1, sd: 32'h1, rq: 1'b1, rdy: 1'b0, exp_err: 1'b0, exp_busy: 1'b0};

    rst_n = 1'b0; seed_load = 1'b0; seed = 32'h0; req = 1'b0; otp_ready = 1'b0;
    m_lfsr = 32'h0; m_seeded = 1'b0; m_consumed = 0;
    repeat (2) tick();
    check("rst_seed_err", {63'd0, seed_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, otp_valid}, 64'd0);
    check("rst_otp", {56'd0, otp}, 64'd0);
    check("rst_count", {48'd0, pad_count}, 64'd0);
    rst_n = 1'b1;
    tick();

    // IDLE control table: seed rejection, unseeded req, stray ready, seed-over-req priority
    for (int i = 0; i < 6; i++) begin
      seed_load = tbl[i].load; seed = tbl[i].sd; req = tbl[i].rq; otp_ready = tbl[i].rdy;
      tick();
      seed_load = 1'b0; req = 1'b0; otp_ready = 1'b0;
      check($sformatf("tbl%0d_err", i), {63'd0, seed_err}, {63'd0, tbl[i].exp_err});
      check($sformatf("tbl%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].exp_busy});
      check($sformatf("tbl%0d_count", i), {48'd0, pad_count}, 64'd0);
      if (tbl[i].load && tbl[i].sd != 32'h0) begin
        m_lfsr = tbl[i].sd;
        m_seeded = 1'b1;
      end
      tick();
      check($sformatf("tbl%0d_err_off", i), {63'd0, seed_err}, 64'd0);
    end

    // first pad from seed 1, then a second pad continuing the sequence
    start_pad(1'b1);
    check("first_pad_9f", {56'd0, otp}, 64'h9F);
    consume();
    start_pad(1'b1);
    consume();

    // pad held under back-pressure; seed_load during PRESENT is rejected, not applied
    start_pad(1'b1);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      seed_load = (i == 5); seed = 32'h0000_1234; otp_ready = 1'b0;
      tick();
      seed_load = 1'b0;
      errs += int'(seed_err);
      check("hold_otp", {56'd0, otp}, {56'd0, sbq[0]});
      check("hold_valid", {63'd0, otp_valid}, 64'd1);
    end
    check("hold_seed_err_count", 64'(errs), 64'd1);
    consume();
    start_pad(1'b1);
    consume();
    start_pad(1'b1);
    consume();
    check("saturated", {62'd0, pad_count2}, 64'd3);

    // reset in the middle of FILL
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_valid", {63'd0, otp_valid}, 64'd0);
    check("mid_rst_otp", {56'd0, otp}, 64'd0);
    check("mid_rst_count", {48'd0, pad_count}, 64'd0);
    check("mid_rst_count_sat", {62'd0, pad_count2}, 64'd0);
    tick();
    rst_n = 1'b1;
    m_seeded = 1'b0; m_consumed = 0; m_lfsr = 32'h0;
    sbq.delete();
    tick();
    start_pad(1'b0);
    seed_load = 1'b1; seed = 32'hACE1_0001;
    tick();
    seed_load = 1'b0;
    m_lfsr = 32'hACE1_0001; m_seeded = 1'b1;
    start_pad(1'b1);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/otp_keystream_gen.md
Name: otp_keystream_gen

Overview:
- Upstream key source for the XOR cipher stage.
- Produces one MSG_SIZE-bit one-time pad per request, drawn from a seeded 32-bit Galois LFSR.
- Bits are shifted out serially and assembled into a pad, then presented on a valid/ready handshake.
- A consumed pad is cleared and never re-presented, so the cipher cannot reuse a key.

Parameters:
- MSG_SIZE, 8: pad width in bits; matches the cipher message width (`MSG_SIZE); legal range 2..64.
- TAPS, 32'hB4BCD35C: right-shift Galois feedback mask (maximal-length polynomial).
- CNT_W, 16: width of the consumed-pad counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- seed_load  input  1  load seed into LFSR (IDLE only)
- seed  input  32  LFSR seed value
- seed_err  output  1  one-cycle pulse: seed rejected
- req  input  1  request generation of the next pad
- busy  output  1  high in FILL or PRESENT
- otp_valid  output  1  pad available on otp
- otp_ready  input  1  consumer accepts pad
- otp  output  MSG_SIZE  one-time pad to the cipher stage
- pad_count  output  CNT_W  number of pads consumed, saturating

Behaviour:
- Reset (async assert, sync release): lfsr=0, seeded=0, state=IDLE, pad=0, bit counter=0, otp=0, otp_valid=0, busy=0, seed_err=0, pad_count=0.
- LFSR step: out=lfsr[0]; lfsr <= (lfsr>>1) ^ (out ? TAPS : 0).
- Pad assembly: pad <= {pad[MSG_SIZE-2:0], out}. The first generated bit ends up in the MSB.
- State IDLE:
  - seed_load with seed!=0: lfsr<=seed, seeded<=1.
  - seed_load with seed==0: seed_err pulses next cycle; lfsr and seeded unchanged.
  - req && seeded: go to FILL, clear pad and bit counter. seed_load has priority if both are asserted; req is then ignored that cycle.
  - req && !seeded: ignored, no error.
- State FILL:
  - One LFSR step per cycle for exactly MSG_SIZE cycles.
  - After the last step, go to PRESENT.
  - req is ignored.
- State PRESENT:
  - otp_valid=1 and otp=pad, held stable until the handshake.
  - On otp_valid && otp_ready: pad_count++ (saturates at all-ones), otp and pad cleared to 0, otp_valid=0 next cycle, return to IDLE.
  - The LFSR does not step outside FILL.
- Latency: req sampled at edge N, so otp_valid rises after edge N+MSG_SIZE+1. A new req is accepted the cycle after the handshake, not the same cycle.
- seed_load in FILL or PRESENT: ignored (LFSR not reseeded); seed_err pulses.
- otp_ready while otp_valid=0: no effect.
- Reset mid-FILL or mid-PRESENT: a partial or unconsumed pad is discarded, seeded=0, and a reseed is required.
- seed_err is registered and is high for exactly one cycle per offending seed_load.

Test Plan:
- Reset, seed_load seed=32'h00000001, req -> busy for MSG_SIZE cycles, then otp_valid=1, otp=8'h9F; with otp_ready=1, pad_count=1 and otp returns to 8'h00.
- Continuing from the previous scenario, req again -> second pad matches a bit-accurate reference model continued from lfsr=32'hDF78A0DD; no repeat of 8'h9F enforced by model comparison.
- seed_load seed=0 in IDLE -> seed_err one-cycle pulse; a following req is ignored (otp_valid stays 0, busy=0).
- In PRESENT, hold otp_ready=0 for 20 cycles while pulsing seed_load seed=32'h1234 -> otp stable at 8'h9F, seed_err pulses once; the next pad still matches the unreseeded model.
- Assert rst_n=0 mid-FILL (cycle 3) -> all outputs 0 immediately; after release, req is ignored until reseeded.
- Preload a CNT_W=2 build, consume 5 pads -> pad_count saturates at 2'b11.
